// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU; result is {remainder, quotient}.
// Optional macro DIV_ZERO_FLAG_EN adds a div_zero_o output flagging divide-by-zero results.
module div_unit #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                signed_div_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  input  logic                start_i,
  input  logic                annul_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o
`ifdef DIV_ZERO_FLAG_EN
  ,
  output logic                div_zero_o
`endif
);

  localparam logic [1:0] FREE    = 2'b00;
  localparam logic [1:0] BY_ZERO = 2'b01;
  localparam logic [1:0] ON      = 2'b10;
  localparam logic [1:0] END     = 2'b11;

  localparam logic [CNT_W-1:0]  LAST_STEP = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0]  ZERO_HOLD = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [DATA_W-1:0] ONE       = DATA_W'(1);

  logic [1:0]        state;
  logic [CNT_W-1:0]  count;
  logic [DATA_W-1:0] rem_q;
  logic [DATA_W-1:0] dvd_q;
  logic [DATA_W-1:0] dsr_q;
  logic              neg_quot;
  logic              neg_rem;

  logic [DATA_W:0]   trial;
  logic [DATA_W-1:0] mag1;
  logic [DATA_W-1:0] mag2;
  logic [DATA_W-1:0] quot_fix;
  logic [DATA_W-1:0] rem_fix;
  logic              start_ok;
  logic              divisor_zero;

  // dvd_q shifts the dividend out at the top while quotient bits enter at the bottom.
  assign trial        = {rem_q, dvd_q[DATA_W-1]} - {1'b0, dsr_q};
  assign mag1         = (signed_div_i && opdata1_i[DATA_W-1]) ? (~opdata1_i + ONE) : opdata1_i;
  assign mag2         = (signed_div_i && opdata2_i[DATA_W-1]) ? (~opdata2_i + ONE) : opdata2_i;
  assign quot_fix     = neg_quot ? (~dvd_q + ONE) : dvd_q;
  assign rem_fix      = neg_rem  ? (~rem_q + ONE) : rem_q;
  assign start_ok     = start_i && !annul_i;
  assign divisor_zero = (opdata2_i == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FREE;
      count    <= '0;
      rem_q    <= '0;
      dvd_q    <= '0;
      dsr_q    <= '0;
      neg_quot <= 1'b0;
      neg_rem  <= 1'b0;
      ready_o  <= 1'b0;
      result_o <= '0;
    end else begin
      case (state)
        FREE: begin
          ready_o  <= 1'b0;
          result_o <= '0;
          if (start_ok) begin
            dvd_q    <= mag1;
            dsr_q    <= mag2;
            rem_q    <= '0;
            neg_quot <= signed_div_i && (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
            neg_rem  <= signed_div_i && opdata1_i[DATA_W-1];
            count    <= '0;
            state    <= divisor_zero ? BY_ZERO : ON;
          end
        end

        // The zero short path dwells two cycles so the result lands two edges after acceptance.
        BY_ZERO: begin
          if (annul_i) begin
            state <= FREE;
            count <= '0;
          end else if (count == ZERO_HOLD) begin
            state    <= END;
            count    <= '0;
            ready_o  <= 1'b1;
            result_o <= '0;
          end else begin
            count <= count + CNT_ONE;
          end
        end

        ON: begin
          if (annul_i) begin
            state    <= FREE;
            count    <= '0;
            ready_o  <= 1'b0;
            result_o <= '0;
          end else if (count == LAST_STEP) begin
            state    <= END;
            count    <= '0;
            ready_o  <= 1'b1;
            result_o <= {rem_fix, quot_fix};
          end else begin
            count <= count + CNT_ONE;
            if (!trial[DATA_W]) begin
              rem_q <= trial[DATA_W-1:0];
              dvd_q <= {dvd_q[DATA_W-2:0], 1'b1};
            end else begin
              rem_q <= {rem_q[DATA_W-2:0], dvd_q[DATA_W-1]};
              dvd_q <= {dvd_q[DATA_W-2:0], 1'b0};
            end
          end
        end

        END: begin
          if (!start_i) begin
            state    <= FREE;
            ready_o  <= 1'b0;
            result_o <= '0;
          end
        end
      endcase
    end
  end

`ifdef DIV_ZERO_FLAG_EN
  // Set only when the result came from the zero short path; dropped when END releases.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_zero_o <= 1'b0;
    end else if (state == BY_ZERO && !annul_i && count == ZERO_HOLD) begin
      div_zero_o <= 1'b1;
    end else if (state == END && !start_i) begin
      div_zero_o <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: transaction-level divide model compared every cycle,
// plus directed vectors with hand-computed results and latencies.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div;
  logic [31:0] opdata1;
  logic [31:0] opdata2;
  logic        start;
  logic        annul;
  logic [63:0] result;
  logic        ready;
`ifdef DIV_ZERO_FLAG_EN
  logic        div_zero;
`endif

  int n_cmp  = 0;
  int n_fail = 0;
  bit checking = 1'b0;

  div_unit #(.DATA_W(32), .CNT_W(6)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div),
    .opdata1_i    (opdata1),
    .opdata2_i    (opdata2),
    .start_i      (start),
    .annul_i      (annul),
    .result_o     (result),
    .ready_o      (ready)
`ifdef DIV_ZERO_FLAG_EN
    ,
    .div_zero_o   (div_zero)
`endif
  );

  always #5 clk = ~clk;

  // Reference quotient/remainder from plain 64-bit integer arithmetic (truncating division).
  function automatic logic [63:0] model_div(input logic s, input logic [31:0] a, input logic [31:0] b);
    longint na, nb, q, r;
    if (b == 32'h0) return 64'h0;
    if (s) begin
      na = longint'($signed(a));
      nb = longint'($signed(b));
    end else begin
      na = longint'({32'h0, a});
      nb = longint'({32'h0, b});
    end
    q = na / nb;
    r = na % nb;
    return {r[31:0], q[31:0]};
  endfunction

  // Transaction-level model: an accepted request completes 33 edges later (2 for a zero divisor).
  bit          m_busy = 1'b0;
  bit          m_done = 1'b0;
  int          m_left = 0;
  logic [63:0] m_pend = '0;
  logic        m_ready = 1'b0;
  logic [63:0] m_result = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_busy   <= 1'b0;
      m_done   <= 1'b0;
      m_ready  <= 1'b0;
      m_result <= '0;
    end else if (m_done) begin
      if (!start) begin
        m_done   <= 1'b0;
        m_ready  <= 1'b0;
        m_result <= '0;
      end
    end else if (m_busy) begin
      if (annul) begin
        m_busy <= 1'b0;
      end else if (m_left == 1) begin
        m_busy   <= 1'b0;
        m_done   <= 1'b1;
        m_ready  <= 1'b1;
        m_result <= m_pend;
      end else begin
        m_left <= m_left - 1;
      end
    end else if (start && !annul) begin
      m_busy <= 1'b1;
      m_left <= (opdata2 == 32'h0) ? 2 : 33;
      m_pend <= model_div(signed_div, opdata1, opdata2);
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      n_cmp = n_cmp + 2;
      if (ready !== m_ready) begin
        n_fail = n_fail + 1;
        $display("[TB] FAIL cycle_ready at %0t: got %b expected %b", $time, ready, m_ready);
      end
      if (result !== m_result) begin
        n_fail = n_fail + 1;
        $display("[TB] FAIL cycle_result at %0t: got %h expected %h", $time, result, m_result);
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Raises start with the operands and returns the edges from acceptance until ready.
  task automatic applyStimulus(input logic s, input logic [31:0] a, input logic [31:0] b, output int lat);
    signed_div = s;
    opdata1    = a;
    opdata2    = b;
    start      = 1'b1;
    @(posedge clk); #1;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!ready && lat < 100);
  endtask

  task automatic releaseStart(input string name);
    start = 1'b0;
    @(posedge clk); #1;
    checkOutput({name, "_drop_ready"}, {63'h0, ready}, 64'h0);
    checkOutput({name, "_drop_result"}, result, 64'h0);
  endtask

  task automatic runOp(input string name, input logic s, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp_res, input int exp_lat);
    int lat;
    applyStimulus(s, a, b, lat);
    checkOutput({name, "_latency"}, 64'(lat), 64'(exp_lat));
    checkOutput({name, "_result"}, result, exp_res);
    @(posedge clk); #1;
    checkOutput({name, "_held"}, result, exp_res);
    releaseStart(name);
  endtask

  initial begin
    int lat;
    bit saw_ready;
    rst = 1'b1; start = 1'b0; annul = 1'b0; signed_div = 1'b0; opdata1 = '0; opdata2 = '0;

    checkOutput("model_u_100_7",   model_div(1'b0, 32'd100, 32'd7),              {32'd2, 32'd14});
    checkOutput("model_s_m7_2",    model_div(1'b1, 32'hFFFFFFF9, 32'h2),         {32'hFFFFFFFF, 32'hFFFFFFFD});
    checkOutput("model_s_ovf",     model_div(1'b1, 32'h80000000, 32'hFFFFFFFF),  {32'h0, 32'h80000000});
    checkOutput("model_u_ovf",     model_div(1'b0, 32'h80000000, 32'hFFFFFFFF),  {32'h80000000, 32'h0});
    checkOutput("model_s_7_m2",    model_div(1'b1, 32'd7, 32'hFFFFFFFE),         {32'd1, 32'hFFFFFFFD});

    repeat (3) @(posedge clk);
    #1;
    checking = 1'b1;
    checkOutput("reset_ready", {63'h0, ready}, 64'h0);
    checkOutput("reset_result", result, 64'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    runOp("u_100_7",   1'b0, 32'd100,      32'd7,        {32'd2, 32'd14}, 33);
    runOp("s_m7_2",    1'b1, 32'hFFFFFFF9, 32'h2,        {32'hFFFFFFFF, 32'hFFFFFFFD}, 33);
    runOp("s_7_m2",    1'b1, 32'd7,        32'hFFFFFFFE, {32'd1, 32'hFFFFFFFD}, 33);
    runOp("s_ovf",     1'b1, 32'h80000000, 32'hFFFFFFFF, {32'h0, 32'h80000000}, 33);
    runOp("u_ovf",     1'b0, 32'h80000000, 32'hFFFFFFFF, {32'h80000000, 32'h0}, 33);

    // Divide by zero: short path.
    applyStimulus(1'b0, 32'h1234, 32'h0, lat);
    checkOutput("zero_latency", 64'(lat), 64'd2);
    checkOutput("zero_result", result, 64'h0);
`ifdef DIV_ZERO_FLAG_EN
    checkOutput("zero_flag", {63'h0, div_zero}, 64'h1);
`endif
    releaseStart("zero");
`ifdef DIV_ZERO_FLAG_EN
    checkOutput("zero_flag_clear", {63'h0, div_zero}, 64'h0);
`endif

    // Annul at step 10 of 1000/3, then a fresh 9/3.
    signed_div = 1'b0; opdata1 = 32'd1000; opdata2 = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    repeat (10) begin @(posedge clk); #1; end
    annul = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    annul = 1'b0;
    saw_ready = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (ready) saw_ready = 1'b1;
    end
    checkOutput("annul_no_ready", {63'h0, saw_ready}, 64'h0);
    runOp("u_9_3", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33);

    // Reset at step 20, then 0xFFFFFFFF/1.
    signed_div = 1'b0; opdata1 = 32'd1000; opdata2 = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    repeat (20) begin @(posedge clk); #1; end
    rst = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    checkOutput("midreset_ready", {63'h0, ready}, 64'h0);
    checkOutput("midreset_result", result, 64'h0);
    rst = 1'b0;
    @(posedge clk); #1;
    runOp("u_max_1", 1'b0, 32'hFFFFFFFF, 32'd1, {32'd0, 32'hFFFFFFFF}, 33);

    repeat (3) @(posedge clk);
    #1;
    checking = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
